// File: rtl/bsg_cache_nb_pkg.sv
// Shared definitions for the bsg_cache_nb initiator bench.
//
// Packet layout, MSB to LSB:
//   src_id [src_id_width]  tag stamped by the initiator, echoed by the cache
//   opcode [6]             bsg_cache_nb_opcode_e
//   addr   [addr_width]
//   data   [data_width]    store data
//   mask   [data_width/8]  byte enables
// src_id sits on top so it can be replaced without touching the payload.
package bsg_cache_nb_pkg;

  localparam int unsigned bsg_cache_nb_opcode_width_gp = 6;

  typedef enum logic [5:0] {
    LB     = 6'h00,
    LH     = 6'h01,
    LW     = 6'h02,
    LD     = 6'h03,
    LBU    = 6'h04,
    LHU    = 6'h05,
    LWU    = 6'h06,
    LDU    = 6'h07,
    SB     = 6'h08,
    SH     = 6'h09,
    SW     = 6'h0A,
    SD     = 6'h0B,
    TAGST  = 6'h10,
    TAGFL  = 6'h11,
    TAGLV  = 6'h12,
    TAGLA  = 6'h13,
    AFL    = 6'h18,
    AFLINV = 6'h19,
    AINV   = 6'h1A
  } bsg_cache_nb_opcode_e;

  // Trace driver control states.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } bsg_cache_nb_drv_state_e;

  // Total packet width for a given configuration.
  function automatic int unsigned bsg_cache_nb_pkt_width(
    input int unsigned addr_width,
    input int unsigned data_width,
    input int unsigned src_id_width
  );
    return src_id_width + bsg_cache_nb_opcode_width_gp
         + addr_width + data_width + data_width / 8;
  endfunction

endpackage

// File: rtl/bsg_priority_encode.sv
// Priority encoder.
//
// Ports:
//   i       request vector
//   addr_o  index of the winning set bit (0 when none set)
//   v_o     any bit of i is set
//
// lo_to_hi_p = 1 gives the lowest set bit priority, 0 the highest.
module bsg_priority_encode #(
  parameter int unsigned width_p    = 8,
  parameter bit          lo_to_hi_p = 1'b1,
  localparam int unsigned addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic [width_p-1:0]       i,
  output logic [addr_width_lp-1:0] addr_o,
  output logic                     v_o
);

  // Scan so that the preferred end is visited last and wins.
  always_comb begin
    addr_o = '0;
    for (int unsigned k = 0; k < width_p; k++) begin
      if (lo_to_hi_p) begin
        if (i[width_p-1-k]) addr_o = addr_width_lp'(width_p - 1 - k);
      end else begin
        if (i[k]) addr_o = addr_width_lp'(k);
      end
    end
  end

  assign v_o = |i;

endmodule

// File: rtl/bsg_cache_nb_trace_driver.sv
// Initiator side of the non-blocking cache interface.
//
// Takes request packets from a trace source, stamps each with a free,
// nonzero src_id, and issues them to the cache through a one-entry output
// register. Responses are retired by src_id. done_o rises once the trace is
// exhausted and every outstanding id has come back.
//
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   trace_pkt_i     request packet from trace (its src_id field is ignored)
//   trace_v_i       trace packet valid
//   trace_done_i    trace exhausted (level)
//   trace_yumi_o    trace packet consumed this cycle
//   cache_pkt_o     stamped packet to cache
//   v_o             cache_pkt_o valid
//   yumi_i          cache accepts cache_pkt_o
//   v_i             response valid
//   src_id_i        response id
//   data_i          response data (consumed by the checker, not here)
//   yumi_o          response consumed (always equals v_i)
//   outstanding_o   number of ids in flight, including the one held in the
//                   output register
//   done_o          trace finished and all responses returned
//   error_o         sticky: response with id 0 or with an id not in flight
module bsg_cache_nb_trace_driver
  import bsg_cache_nb_pkg::*;
#(
  parameter int unsigned addr_width_p      = 32,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned src_id_width_p    = 3,
  parameter int unsigned max_outstanding_p = (1 << src_id_width_p) - 1,
  localparam int unsigned cache_pkt_width_lp =
    bsg_cache_nb_pkt_width(addr_width_p, data_width_p, src_id_width_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [cache_pkt_width_lp-1:0] trace_pkt_i,
  input  logic                          trace_v_i,
  input  logic                          trace_done_i,
  output logic                          trace_yumi_o,

  output logic [cache_pkt_width_lp-1:0] cache_pkt_o,
  output logic                          v_o,
  input  logic                          yumi_i,

  input  logic                          v_i,
  input  logic [src_id_width_p-1:0]     src_id_i,
  input  logic [data_width_p-1:0]       data_i,
  output logic                          yumi_o,

  output logic [src_id_width_p:0]       outstanding_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam int unsigned num_ids_lp       = 1 << src_id_width_p;
  localparam int unsigned payload_width_lp = cache_pkt_width_lp - src_id_width_p;
  localparam logic [src_id_width_p:0] max_out_lp = (src_id_width_p + 1)'(max_outstanding_p);
  localparam logic [src_id_width_p:0] one_lp     = (src_id_width_p + 1)'(1);

  // Registered state.
  bsg_cache_nb_drv_state_e         state_r, state_n;
  logic [num_ids_lp-1:0]           free_r, free_n;
  logic [src_id_width_p:0]         outstanding_r, outstanding_n;
  logic                            full_r;
  logic [payload_width_lp-1:0]     payload_r;
  logic [src_id_width_p-1:0]       id_r;
  logic                            error_r;

  // Id selection.
  logic [num_ids_lp-1:0]           free_cand;
  logic [src_id_width_p-1:0]       alloc_id;
  logic                            alloc_v;

  logic                            accept_state;
  logic                            room;
  logic                            trace_yumi;
  logic                            issue;
  logic                            resp_hit;
  logic                            resp_err;

  // The incoming src_id field is overwritten and response data is checked
  // elsewhere.
  logic unused_inputs;
  assign unused_inputs = ^{data_i, trace_pkt_i[cache_pkt_width_lp-1 -: src_id_width_p]};

  // Id 0 is reserved, so it is never offered to the encoder. The encoder
  // reads the registered vector: an id freed this cycle is only eligible
  // from the next cycle on.
  assign free_cand = {free_r[num_ids_lp-1:1], 1'b0};

  bsg_priority_encode #(
    .width_p   (num_ids_lp),
    .lo_to_hi_p(1'b1)
  ) alloc_enc (
    .i     (free_cand),
    .addr_o(alloc_id),
    .v_o   (alloc_v)
  );

  assign accept_state = (state_r == IDLE) || (state_r == RUN);
  assign room         = (outstanding_r < max_out_lp);
  assign issue        = full_r & yumi_i;

  // The register may be refilled in the same cycle it is drained.
  assign trace_yumi = ~reset_i & accept_state & trace_v_i & alloc_v & room
                    & (~full_r | yumi_i);

  // A hit needs an in-flight id, so it can never equal the id being
  // allocated in the same cycle.
  assign resp_hit = v_i & (src_id_i != '0) & ~free_r[src_id_i];
  assign resp_err = v_i & ~resp_hit;

  always_comb begin
    free_n = free_r;
    if (trace_yumi) free_n[alloc_id] = 1'b0;
    if (resp_hit)   free_n[src_id_i] = 1'b1;
  end

  always_comb begin
    outstanding_n = outstanding_r;
    if (trace_yumi && !resp_hit) begin
      outstanding_n = outstanding_r + one_lp;
    end else if (!trace_yumi && resp_hit) begin
      outstanding_n = outstanding_r - one_lp;
    end
  end

  // DRAIN looks at the post-update count so a final response moves the
  // FSM to DONE in the cycle it arrives.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:  state_n = RUN;
      RUN:   if (trace_done_i && !trace_v_i && !full_r) state_n = DRAIN;
      DRAIN: if (outstanding_n == '0) state_n = DONE;
      DONE:  state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= IDLE;
      free_r        <= {{(num_ids_lp-1){1'b1}}, 1'b0};
      outstanding_r <= '0;
      full_r        <= 1'b0;
      payload_r     <= '0;
      id_r          <= '0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_n;
      free_r        <= free_n;
      outstanding_r <= outstanding_n;
      if (resp_err) error_r <= 1'b1;
      if (trace_yumi) begin
        full_r    <= 1'b1;
        payload_r <= trace_pkt_i[payload_width_lp-1:0];
        id_r      <= alloc_id;
      end else if (issue) begin
        full_r <= 1'b0;
      end
    end
  end

  assign trace_yumi_o  = trace_yumi;
  assign cache_pkt_o   = {id_r, payload_r};
  assign v_o           = full_r;
  assign yumi_o        = v_i;
  assign outstanding_o = outstanding_r;
  assign done_o        = (state_r == DONE);
  assign error_o       = error_r;

endmodule

// File: tb/tb_bsg_cache_nb_trace_driver.sv
module tb_bsg_cache_nb_trace_driver;
  import bsg_cache_nb_pkg::*;

  localparam int unsigned aw = 32;
  localparam int unsigned dw = 32;
  localparam int unsigned sw = 3;
  localparam int unsigned pw = bsg_cache_nb_pkt_width(aw, dw, sw);

  typedef struct packed {
    logic [sw-1:0]   src_id;
    logic [5:0]      opcode;
    logic [aw-1:0]   addr;
    logic [dw-1:0]   data;
    logic [dw/8-1:0] mask;
  } pkt_s;

  typedef struct {
    logic       v;
    logic [2:0] id;
    logic       exp_err;
    logic [3:0] exp_out;
  } resp_vec_s;

  logic          clk;
  logic          reset_i;
  logic [pw-1:0] trace_pkt_i;
  logic          trace_v_i;
  logic          trace_done_i;
  logic          trace_yumi_o;
  logic [pw-1:0] cache_pkt_o;
  logic          v_o;
  logic          yumi_i;
  logic          v_i;
  logic [sw-1:0] src_id_i;
  logic [dw-1:0] data_i;
  logic          yumi_o;
  logic [sw:0]   outstanding_o;
  logic          done_o;
  logic          error_o;

  bsg_cache_nb_trace_driver #(
    .addr_width_p     (aw),
    .data_width_p     (dw),
    .src_id_width_p   (sw),
    .max_outstanding_p(7)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .trace_pkt_i  (trace_pkt_i),
    .trace_v_i    (trace_v_i),
    .trace_done_i (trace_done_i),
    .trace_yumi_o (trace_yumi_o),
    .cache_pkt_o  (cache_pkt_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .v_i          (v_i),
    .src_id_i     (src_id_i),
    .data_i       (data_i),
    .yumi_o       (yumi_o),
    .outstanding_o(outstanding_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic pkt_s make_pkt(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    pkt_s p;
    p.src_id = sw'($urandom_range(0, 7));
    p.opcode = op;
    p.addr   = addr;
    p.data   = data;
    p.mask   = 4'hF;
    return p;
  endfunction

  function automatic pkt_s stamp(input pkt_s p, input int unsigned id);
    pkt_s s;
    s = p;
    s.src_id = sw'(id);
    return s;
  endfunction

  function automatic logic [2:0] id_of(input logic [pw-1:0] v);
    pkt_s s;
    s = v;
    return s.src_id;
  endfunction

  function automatic int unsigned lowest_free(input logic [7:0] f);
    for (int unsigned k = 1; k < 8; k++) if (f[k]) return k;
    return 0;
  endfunction

  // Reference model of id allocation and retirement, plus the scoreboard
  // of packets expected on the cache side.
  pkt_s        exp_q[$];
  logic [7:0]  m_free = 8'hFE;
  int          m_cnt  = 0;
  logic        m_err  = 1'b0;

  always @(negedge clk) begin : monitor
    int unsigned id;
    pkt_s        e;
    check("outstanding_track", outstanding_o, m_cnt);
    check("error_track", error_o, m_err);
    check("resp_ack", yumi_o, v_i);
    if (reset_i) begin
      m_free = 8'hFE;
      m_cnt  = 0;
      m_err  = 1'b0;
      exp_q.delete();
    end else begin
      if (v_o && yumi_i) begin
        if (exp_q.size() == 0) begin
          check("issue_expected", v_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("issue_pkt", cache_pkt_o, e);
        end
      end
      if (trace_v_i && trace_yumi_o) begin
        id = lowest_free(m_free);
        if (id == 0 || m_cnt >= 7) begin
          check("alloc_allowed", trace_yumi_o, 1'b0);
        end else begin
          exp_q.push_back(stamp(pkt_s'(trace_pkt_i), id));
          m_free[id] = 1'b0;
          m_cnt++;
        end
      end
      if (v_i) begin
        if (src_id_i != 0 && !m_free[src_id_i]) begin
          m_free[src_id_i] = 1'b1;
          m_cnt--;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    trace_v_i    = 1'b0;
    trace_done_i = 1'b0;
    yumi_i       = 1'b0;
    v_i          = 1'b0;
    src_id_i     = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  resp_vec_s tbl[7];
  pkt_s      p0, p1;

  initial begin
    tbl[0] = '{v: 1'b0, id: 3'd0, exp_err: 1'b0, exp_out: 4'd2};
    tbl[1] = '{v: 1'b1, id: 3'd0, exp_err: 1'b1, exp_out: 4'd2};
    tbl[2] = '{v: 1'b1, id: 3'd5, exp_err: 1'b1, exp_out: 4'd2};
    tbl[3] = '{v: 1'b0, id: 3'd0, exp_err: 1'b1, exp_out: 4'd2};
    tbl[4] = '{v: 1'b1, id: 3'd2, exp_err: 1'b1, exp_out: 4'd1};
    tbl[5] = '{v: 1'b1, id: 3'd2, exp_err: 1'b1, exp_out: 4'd1};
    tbl[6] = '{v: 1'b1, id: 3'd1, exp_err: 1'b1, exp_out: 4'd0};

    data_i      = 32'h1234_5678;
    trace_pkt_i = '0;
    idle_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;

    // Reset state.
    check("rst_v_o", v_o, 1'b0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_done", done_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_trace_yumi", trace_yumi_o, 1'b0);
    check("rst_pkt", cache_pkt_o, 0);

    // Single store through to done.
    p0 = make_pkt(SW, 32'h10, 32'hDEADBEEF);
    trace_pkt_i = p0;
    trace_v_i   = 1'b1;
    neg();
    check("s1_trace_yumi", trace_yumi_o, 1'b1);
    step();
    trace_v_i    = 1'b0;
    trace_done_i = 1'b1;
    yumi_i       = 1'b1;
    check("s1_v_o", v_o, 1'b1);
    check("s1_out1", outstanding_o, 1);
    check("s1_src_id", id_of(cache_pkt_o), 3'd1);
    check("s1_pkt", cache_pkt_o, stamp(p0, 1));
    step();
    yumi_i = 1'b0;
    check("s1_v_o_drained", v_o, 1'b0);
    check("s1_out_inflight", outstanding_o, 1);
    step();
    v_i      = 1'b1;
    src_id_i = 3'd1;
    check("s1_not_done", done_o, 1'b0);
    step();
    v_i = 1'b0;
    check("s1_done", done_o, 1'b1);
    check("s1_out0", outstanding_o, 0);
    trace_pkt_i = make_pkt(LW, 32'h20, 32'h0);
    trace_v_i   = 1'b1;
    neg();
    check("s1_done_blocks_trace", trace_yumi_o, 1'b0);
    step();
    check("s1_done_sticky", done_o, 1'b1);
    do_reset();

    // Eight back-to-back loads with no responses.
    yumi_i = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      trace_pkt_i = make_pkt(LW, 32'(4 * i), $urandom);
      trace_v_i   = 1'b1;
      neg();
      check("b2b_trace_yumi", trace_yumi_o, (i < 7) ? 1'b1 : 1'b0);
      step();
    end
    check("b2b_out7", outstanding_o, 7);
    check("b2b_reg_empty", v_o, 1'b0);
    v_i      = 1'b1;
    src_id_i = 3'd4;
    neg();
    check("b2b_full_on_resp", trace_yumi_o, 1'b0);
    step();
    v_i = 1'b0;
    neg();
    check("b2b_realloc_yumi", trace_yumi_o, 1'b1);
    step();
    trace_v_i = 1'b0;
    check("b2b_realloc_v", v_o, 1'b1);
    check("b2b_realloc_id", id_of(cache_pkt_o), 3'd4);
    step();
    yumi_i = 1'b0;
    check("b2b_out_after", outstanding_o, 7);
    do_reset();

    // Cache stalls for five cycles.
    p0 = make_pkt(SB, 32'h40, 32'hA5);
    p1 = make_pkt(SH, 32'h44, 32'h5A5A);
    trace_pkt_i = p0;
    trace_v_i   = 1'b1;
    neg();
    check("stall_first_yumi", trace_yumi_o, 1'b1);
    step();
    trace_pkt_i = p1;
    for (int unsigned k = 0; k < 5; k++) begin
      neg();
      check("stall_v_o", v_o, 1'b1);
      check("stall_pkt", cache_pkt_o, stamp(p0, 1));
      check("stall_trace_yumi", trace_yumi_o, 1'b0);
      step();
    end
    yumi_i = 1'b1;
    neg();
    check("stall_release_yumi", trace_yumi_o, 1'b1);
    step();
    yumi_i      = 1'b0;
    trace_pkt_i = make_pkt(SW, 32'h48, 32'h0);
    neg();
    check("stall_refill_pkt", cache_pkt_o, stamp(p1, 2));
    check("stall_refill_block", trace_yumi_o, 1'b0);
    check("stall_out2", outstanding_o, 2);
    step();
    do_reset();

    // Allocate and retire in the same cycle.
    yumi_i = 1'b1;
    trace_v_i = 1'b1;
    trace_pkt_i = make_pkt(LW, 32'h80, 32'h0);
    step();
    trace_pkt_i = make_pkt(LW, 32'h84, 32'h0);
    step();
    trace_pkt_i = make_pkt(LW, 32'h88, 32'h0);
    v_i      = 1'b1;
    src_id_i = 3'd1;
    neg();
    check("same_out_before", outstanding_o, 2);
    check("same_trace_yumi", trace_yumi_o, 1'b1);
    step();
    v_i = 1'b0;
    trace_pkt_i = make_pkt(LW, 32'h8C, 32'h0);
    neg();
    check("same_out_unchanged", outstanding_o, 2);
    check("same_id_not_reused", id_of(cache_pkt_o), 3'd3);
    step();
    trace_v_i = 1'b0;
    neg();
    check("same_id_next_cycle", id_of(cache_pkt_o), 3'd1);
    check("same_out_after", outstanding_o, 3);
    step();
    yumi_i = 1'b0;
    do_reset();

    // Response table: bad ids, double retire, normal retire.
    yumi_i = 1'b1;
    trace_v_i = 1'b1;
    trace_pkt_i = make_pkt(LW, 32'hC0, 32'h0);
    step();
    trace_pkt_i = make_pkt(LW, 32'hC4, 32'h0);
    step();
    trace_v_i = 1'b0;
    step();
    yumi_i = 1'b0;
    check("tbl_setup_out", outstanding_o, 2);
    for (int unsigned t = 0; t < 7; t++) begin
      v_i      = tbl[t].v;
      src_id_i = tbl[t].id;
      neg();
      check("tbl_ack", yumi_o, tbl[t].v);
      step();
      check("tbl_error", error_o, tbl[t].exp_err);
      check("tbl_outstanding", outstanding_o, tbl[t].exp_out);
    end
    v_i = 1'b0;
    do_reset();
    check("err_cleared", error_o, 1'b0);

    // Reset with three ids outstanding and a full register.
    yumi_i = 1'b1;
    trace_v_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      trace_pkt_i = make_pkt(SW, 32'(32'h100 + 4 * i), $urandom);
      step();
    end
    trace_v_i = 1'b0;
    yumi_i    = 1'b0;
    check("mid_v_o", v_o, 1'b1);
    check("mid_out3", outstanding_o, 3);
    check("mid_held_id", id_of(cache_pkt_o), 3'd3);
    reset_i  = 1'b1;
    v_i      = 1'b1;
    src_id_i = 3'd1;
    neg();
    check("mid_reset_ack", yumi_o, 1'b1);
    step();
    check("mid_v_o_dropped", v_o, 1'b0);
    check("mid_out0", outstanding_o, 0);
    check("mid_done0", done_o, 1'b0);
    check("mid_err0", error_o, 1'b0);
    reset_i = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b1;
    trace_pkt_i = make_pkt(LW, 32'h200, 32'h0);
    trace_v_i   = 1'b1;
    neg();
    check("mid_realloc_yumi", trace_yumi_o, 1'b1);
    step();
    trace_v_i = 1'b0;
    check("mid_realloc_id", id_of(cache_pkt_o), 3'd1);
    check("mid_realloc_v", v_o, 1'b1);
    step();
    yumi_i = 1'b0;
    check("sb_drained", exp_q.size(), 0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
